a0_trace_fifo: RTL



---
 rtl/a0_trace_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: captures every change of the CPU's a0 register into a
// show-ahead FIFO drained through a valid/ready port. Captures that arrive
// while the FIFO is full and not draining are dropped, flagged and counted.
module a0_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a0_in,
  input  logic                     capture_en,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] a0_prev;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             chg;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  // Push/pop/drop decisions; a full FIFO still accepts a push when it pops on the same edge.
  always_comb begin
    chg     = capture_en && (a0_in != a0_prev);
    full    = (count == FULL_CNT);
    do_pop  = out_valid && out_ready;
    do_push = chg && (!full || do_pop);
    drop    = chg && full && !do_pop;
  end

  // Show-ahead head entry, forced to zero when empty.
  always_comb begin
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

  // Change tracker follows a0 every cycle, independent of capture_en.
  always_ff @(posedge clk) begin
    if (rst) a0_prev <= '0;
    else     a0_prev <= a0_in;
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= a0_in;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Drop bookkeeping; a drop on the same edge as clear_ovf leaves one counted drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_ovf)                  drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
